// File: rtl/qpsk_tx_pkg.sv
// qpsk_tx_pkg: shared FSM/segment types, frame constants and the
// header packing helper for the QPSK transmit frame scheduler.
package qpsk_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SEG_PRE,
    SEG_HDR,
    SEG_PAY
  } seg_t;

  localparam int SYMS_PER_WORD = 11;
  localparam int DRAIN_LIMIT = 4;

  localparam logic [4:0] SYNC_DEF = 5'b11011;
  localparam logic [20:0] PRE_PATTERN_DEF = 21'h155555;

  // Header word: sync field, frame sequence number, payload length-1.
  function automatic logic [20:0] hdr_pack(
    input logic [4:0] sync,
    input logic [7:0] seq,
    input logic [7:0] len_m1
  );
    return {sync, seq, len_m1};
  endfunction

endpackage

// File: rtl/qpsk_tx_frame_scheduler_pacer.sv
// qpsk_sym_pacer: clock divider producing a one-cycle advance strobe
// every SYM_DIV enabled clocks, plus a count of strobes since clear.
// Ports: clk, reset (async high), clr (sync clear), en (count enable),
//        adv (advance strobe), adv_cnt (advances since clear).
module qpsk_sym_pacer #(
  parameter int SYM_DIV = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic             adv,
  output logic [CNT_W-1:0] adv_cnt
);

  localparam int DIV_W = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SYM_DIV - 1);

  logic [DIV_W-1:0] div;

  // Strobe only on an enabled cycle so a stalled mapper never
  // sees an advance.
  assign adv = en && (div == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div     <= '0;
      adv_cnt <= '0;
    end else if (clr) begin
      div     <= '0;
      adv_cnt <= '0;
    end else if (adv) begin
      div     <= '0;
      adv_cnt <= adv_cnt + CNT_W'(1);
    end else if (en) begin
      div     <= div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/qpsk_tx_frame_scheduler.sv
// qpsk_tx_frame_scheduler: drives the QPSK word mapper through one
// frame (preamble words, header word, payload words).
// Ports: clk/reset; start, len_m1, abort frame control; pay_valid,
//   pay_data, pay_ready payload source; map_reset, map_load, map_word,
//   map_advance, map_writeready, map_complete mapper handshake;
//   busy, frame_done, underrun, seq status.
module qpsk_tx_frame_scheduler
  import qpsk_tx_pkg::*;
#(
  parameter int              WORD_W      = 21,
  parameter int              SYM_DIV     = 16,
  parameter int              PRE_WORDS   = 2,
  parameter logic [WORD_W-1:0] PRE_PATTERN = WORD_W'(PRE_PATTERN_DEF),
  parameter logic [4:0]      SYNC        = SYNC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        len_m1,
  input  logic              abort,
  input  logic              pay_valid,
  input  logic [WORD_W-1:0] pay_data,
  output logic              pay_ready,
  output logic              map_reset,
  output logic              map_load,
  output logic [WORD_W-1:0] map_word,
  output logic              map_advance,
  input  logic              map_writeready,
  input  logic              map_complete,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun,
  output logic [7:0]        seq
);

  localparam int CNT_W = 4;
  localparam logic [7:0] PRE_LAST = 8'(PRE_WORDS - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_LIMIT - 1);
  localparam logic [CNT_W-1:0] ADV_LAST = CNT_W'(SYMS_PER_WORD - 1);

  state_t state;
  state_t state_nxt;
  seg_t   seg;

  logic [7:0]       word_cnt;
  logic [7:0]       len;
  logic [1:0]       drain_cnt;
  logic             adv;
  logic [CNT_W-1:0] adv_cnt;
  logic             abort_act;
  logic             last_adv;
  logic             seg_last;
  logic             timeout;

  // Abort only acts on a frame in flight.
  assign abort_act = abort && (state != ST_IDLE);
  assign last_adv  = adv && (adv_cnt == ADV_LAST);
  assign timeout   = (state == ST_DRAIN) && !map_complete &&
                     (drain_cnt == DRAIN_LAST);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    seg_last = 1'b1;
    unique case (seg)
      SEG_PRE: seg_last = (word_cnt == PRE_LAST);
      SEG_HDR: seg_last = 1'b1;
      SEG_PAY: seg_last = (word_cnt == len);
      default: seg_last = 1'b1;
    endcase
  end

  // Divider is held clear outside STREAM, so each word starts at 0.
  qpsk_sym_pacer #(
    .SYM_DIV (SYM_DIV),
    .CNT_W   (CNT_W)
  ) u_pacer (
    .clk     (clk),
    .reset   (reset),
    .clr     (state != ST_STREAM),
    .en      ((state == ST_STREAM) && map_writeready),
    .adv     (adv),
    .adv_cnt (adv_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort_act) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) state_nxt = ST_LOAD;
        end
        ST_LOAD: state_nxt = ST_STREAM;
        ST_STREAM: begin
          if (last_adv) state_nxt = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (map_complete) begin
            if (seg == SEG_PAY && seg_last) state_nxt = ST_DONE;
            else state_nxt = ST_LOAD;
          end else if (timeout) begin
            state_nxt = ST_DONE;
          end
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg       <= SEG_PRE;
      word_cnt  <= '0;
      len       <= '0;
      seq       <= '0;
      drain_cnt <= '0;
    end else begin
      if (state == ST_DRAIN && !abort_act) drain_cnt <= drain_cnt + 2'd1;
      else drain_cnt <= '0;
      if (!abort_act) begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              len      <= len_m1;
              seg      <= SEG_PRE;
              word_cnt <= '0;
            end
          end
          ST_DRAIN: begin
            if (map_complete) begin
              if (!seg_last) begin
                word_cnt <= word_cnt + 8'd1;
              end else begin
                word_cnt <= '0;
                unique case (seg)
                  SEG_PRE: seg <= SEG_HDR;
                  SEG_HDR: seg <= SEG_PAY;
                  default: seg <= seg;
                endcase
              end
            end
          end
          ST_DONE: seq <= seq + 8'd1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    map_load    = 1'b0;
    map_word    = '0;
    map_advance = 1'b0;
    pay_ready   = 1'b0;
    underrun    = 1'b0;
    frame_done  = 1'b0;
    // Mapper is held in reset with ours, and pulsed on abort/timeout.
    map_reset   = reset || abort_act || timeout;
    if (!abort_act) begin
      unique case (state)
        ST_LOAD: begin
          map_load = 1'b1;
          unique case (seg)
            SEG_PRE: map_word = PRE_PATTERN;
            SEG_HDR: map_word = WORD_W'(hdr_pack(SYNC, seq, len));
            SEG_PAY: begin
              // Starved source: send a zero filler word instead.
              if (pay_valid) begin
                map_word  = pay_data;
                pay_ready = 1'b1;
              end else begin
                underrun  = 1'b1;
              end
            end
            default: map_word = '0;
          endcase
        end
        ST_STREAM: map_advance = adv;
        ST_DONE:   frame_done  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qpsk_tx_frame_scheduler.sv
// tb_qpsk_tx_frame_scheduler: scoreboard bench with a behavioural
// mapper, payload source and frame-level expectation model.
module tb_qpsk_tx_frame_scheduler;

  localparam int          SYM_DIV   = 16;
  localparam int          PRE_WORDS = 2;
  localparam int          SYMS      = 11;
  localparam logic [20:0] PRE_PAT   = 21'h155555;
  localparam logic [4:0]  SYNC_F    = 5'b11011;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  len_m1;
  logic        abort;
  logic        pay_valid;
  logic [20:0] pay_data;
  logic        pay_ready;
  logic        map_reset;
  logic        map_load;
  logic [20:0] map_word;
  logic        map_advance;
  logic        map_writeready;
  logic        map_complete;
  logic        busy;
  logic        frame_done;
  logic        underrun;
  logic [7:0]  seq;

  qpsk_tx_frame_scheduler #(
    .WORD_W      (21),
    .SYM_DIV     (SYM_DIV),
    .PRE_WORDS   (PRE_WORDS),
    .PRE_PATTERN (PRE_PAT),
    .SYNC        (SYNC_F)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .len_m1         (len_m1),
    .abort          (abort),
    .pay_valid      (pay_valid),
    .pay_data       (pay_data),
    .pay_ready      (pay_ready),
    .map_reset      (map_reset),
    .map_load       (map_load),
    .map_word       (map_word),
    .map_advance    (map_advance),
    .map_writeready (map_writeready),
    .map_complete   (map_complete),
    .busy           (busy),
    .frame_done     (frame_done),
    .underrun       (underrun),
    .seq            (seq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [20:0] word;
    bit          pay;
    bit          valid;
  } exp_t;

  typedef struct {
    bit          valid;
    logic [20:0] data;
  } src_t;

  exp_t exp_q[$];
  src_t src_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int n_adv = 0, n_prdy = 0, n_und = 0, n_done = 0, n_mrst = 0;
  int s_adv, s_prdy, s_und, s_done, s_mrst;
  int e_adv, e_prdy, e_und, e_done;
  int wr_cnt = 0;
  int syms = 0;
  bit cmpl = 0;
  bit dead = 0;
  bit wr_rand = 0;
  logic [7:0] seq_m = 8'd0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Monitor and mapper model: observe each cycle away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      syms = 0;
      cmpl = 0;
      wr_cnt = 0;
    end else begin
      chk("load_adv_excl", {31'b0, map_load & map_advance}, 0);
      if (map_reset) begin
        n_mrst++;
        syms = 0;
        cmpl = 0;
      end
      if (map_load) begin
        wr_cnt = 0;
        syms = 0;
        cmpl = 0;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_load: got word %0h, expected no load",
                   map_word);
        end else begin
          e = exp_q.pop_front();
          chk("map_word", map_word, e.word);
          chk("pay_ready", pay_ready, e.pay && e.valid);
          chk("underrun", underrun, e.pay && !e.valid);
          if (e.pay && src_q.size() > 0) void'(src_q.pop_front());
        end
      end else begin
        chk("pay_ready_idle", pay_ready, 0);
        if (map_writeready) wr_cnt++;
        if (map_advance) begin
          chk("adv_spacing", wr_cnt, SYM_DIV);
          wr_cnt = 0;
          syms++;
          n_adv++;
          if (syms == SYMS) cmpl = 1;
        end
      end
      if (pay_ready) n_prdy++;
      if (underrun) n_und++;
      if (frame_done) n_done++;
    end
  end

  // Input drivers for the mapper flags and payload source.
  always @(posedge clk) begin
    #1;
    map_complete = cmpl && !dead;
    map_writeready = wr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (src_q.size() > 0) begin
      pay_valid = src_q[0].valid;
      pay_data  = src_q[0].data;
    end else begin
      pay_valid = 1'b0;
      pay_data  = '0;
    end
  end

  task automatic snap();
    s_adv = n_adv; s_prdy = n_prdy; s_und = n_und;
    s_done = n_done; s_mrst = n_mrst;
    e_adv = 0; e_prdy = 0; e_und = 0; e_done = 0;
  endtask

  task automatic queue_frame(input logic [7:0] len, input logic [31:0] mask,
                             input int drop_pct, input logic [7:0] hs);
    exp_t e;
    src_t s;
    logic [31:0] d;
    for (int i = 0; i < PRE_WORDS; i++) begin
      e.word = PRE_PAT; e.pay = 0; e.valid = 0;
      exp_q.push_back(e);
    end
    e.word = {SYNC_F, hs, len}; e.pay = 0; e.valid = 0;
    exp_q.push_back(e);
    for (int i = 0; i <= int'(len); i++) begin
      d = $urandom;
      s.data = d[20:0];
      s.valid = !(i < 32 && mask[i]) &&
                ($urandom_range(0, 99) >= drop_pct);
      src_q.push_back(s);
      e.word = s.valid ? s.data : 21'h0;
      e.pay = 1; e.valid = s.valid;
      exp_q.push_back(e);
      if (s.valid) e_prdy++; else e_und++;
    end
    e_adv += SYMS * (PRE_WORDS + 2 + int'(len));
    e_done++;
  endtask

  task automatic start_frame(input logic [7:0] len, input bit with_abort);
    @(posedge clk); #1;
    start = 1; len_m1 = len; abort = with_abort;
    @(posedge clk); #1;
    start = 0; abort = 0; len_m1 = 8'($urandom);
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (frame_done) begin
        got = 1;
        break;
      end
    end
    chk(name, got, 1);
  endtask

  task automatic count_adv(input string name, input int target);
    int cnt = 0;
    for (int i = 0; i < 20000 && cnt < target; i++) begin
      @(negedge clk);
      if (map_advance) cnt++;
    end
    chk(name, cnt, target);
  endtask

  task automatic end_checks(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_words_left"}, exp_q.size(), 0);
    chk({tag, "_adv"}, n_adv - s_adv, e_adv);
    chk({tag, "_pay_ready"}, n_prdy - s_prdy, e_prdy);
    chk({tag, "_underrun"}, n_und - s_und, e_und);
    chk({tag, "_done"}, n_done - s_done, e_done);
    chk({tag, "_map_reset"}, n_mrst - s_mrst, 0);
    chk({tag, "_seq"}, seq, seq_m);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    exp_t e;
    reset = 1; start = 0; len_m1 = 0; abort = 0;
    pay_valid = 0; pay_data = 0;
    map_writeready = 1; map_complete = 0;
    repeat (3) @(negedge clk);
    chk("rst_map_reset", map_reset, 1);
    chk("rst_outputs", {map_load, map_advance, pay_ready, busy,
                        frame_done, underrun}, 0);
    chk("rst_seq", seq, 0);
    chk("rst_word", map_word, 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("rel_map_reset", map_reset, 0);
    chk("rel_busy", busy, 0);

    // Minimal frame, all payload available.
    snap();
    queue_frame(8'd0, 0, 0, seq_m);
    start_frame(8'd0, 0);
    wait_done("t1_done");
    seq_m++;
    end_checks("t1");

    // Second payload word starved.
    snap();
    queue_frame(8'd3, 32'h2, 0, seq_m);
    start_frame(8'd3, 0);
    wait_done("t2_done");
    seq_m++;
    end_checks("t2");

    // Abort on the 5th header advance.
    snap();
    queue_frame(8'd1, 0, 0, seq_m);
    start_frame(8'd1, 0);
    count_adv("t3_adv_reach", PRE_WORDS * SYMS + 4);
    repeat (15) @(negedge clk);
    @(posedge clk); #1 abort = 1;
    @(negedge clk);
    chk("t3_abort_map_reset", map_reset, 1);
    chk("t3_abort_forced", {map_load, map_advance, pay_ready}, 0);
    @(posedge clk); #1 abort = 0;
    exp_q.delete();
    src_q.delete();
    @(negedge clk);
    chk("t3_idle_busy", busy, 0);
    chk("t3_idle_map_reset", map_reset, 0);
    repeat (3) @(negedge clk);
    chk("t3_no_done", n_done - s_done, 0);
    chk("t3_one_reset", n_mrst - s_mrst, 1);
    chk("t3_seq", seq, seq_m);
    @(posedge clk); #1 abort = 1;
    @(negedge clk);
    chk("t3_idle_abort_noop", {map_reset, busy}, 0);
    @(posedge clk); #1 abort = 0;

    snap();
    queue_frame(8'd1, 0, 0, seq_m);
    start_frame(8'd1, 0);
    wait_done("t3b_done");
    seq_m++;
    end_checks("t3b");

    // Start held high: second frame only after DONE.
    snap();
    queue_frame(8'd1, 0, 0, seq_m);
    queue_frame(8'd0, 0, 0, seq_m + 8'd1);
    @(posedge clk); #1 start = 1; len_m1 = 8'd1;
    @(posedge clk); #1 len_m1 = 8'd0;
    wait_done("t4_done1");
    seq_m++;
    @(negedge clk);
    chk("t4_seq1", seq, seq_m);
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
    chk("t4_restart", busy, 1);
    @(posedge clk); #1 start = 0;
    wait_done("t4_done2");
    seq_m++;
    end_checks("t4");

    // Mapper never completes: timeout after four drain cycles.
    snap();
    dead = 1;
    e.word = PRE_PAT; e.pay = 0; e.valid = 0;
    exp_q.push_back(e);
    start_frame(8'd0, 0);
    count_adv("t5_adv", SYMS);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("t5_timeout_reset", map_reset, (i == 4));
    end
    @(negedge clk);
    chk("t5_frame_done", frame_done, 1);
    seq_m++;
    repeat (2) @(negedge clk);
    dead = 0;
    chk("t5_words_left", exp_q.size(), 0);
    chk("t5_one_reset", n_mrst - s_mrst, 1);
    chk("t5_done", n_done - s_done, 1);
    chk("t5_seq", seq, seq_m);

    // Random frames with a stalling mapper; first start collides
    // with abort in IDLE.
    wr_rand = 1;
    for (int f = 0; f < 4; f++) begin
      logic [7:0] len;
      len = 8'($urandom_range(0, 5));
      snap();
      queue_frame(len, 0, 30, seq_m);
      start_frame(len, f == 0);
      @(negedge clk);
      chk("rnd_started", busy, 1);
      wait_done("rnd_done");
      seq_m++;
      end_checks("rnd");
    end

    // Asynchronous reset mid-STREAM.
    wr_rand = 0;
    queue_frame(8'd2, 0, 0, seq_m);
    start_frame(8'd2, 0);
    count_adv("t6_adv", 5);
    @(posedge clk); #3 reset = 1;
    #1;
    chk("t6_async_outputs", {map_load, map_advance, pay_ready, busy,
                             frame_done, underrun}, 0);
    chk("t6_async_word", map_word, 0);
    chk("t6_async_seq", seq, 0);
    chk("t6_async_map_reset", map_reset, 1);
    repeat (3) begin
      @(negedge clk);
      chk("t6_hold_map_reset", map_reset, 1);
    end
    @(posedge clk); #1 reset = 0;
    exp_q.delete();
    src_q.delete();
    seq_m = 8'd0;
    @(negedge clk);
    chk("t6_release", {map_reset, busy}, 0);

    wr_rand = 1;
    snap();
    queue_frame(8'd1, 0, 20, seq_m);
    start_frame(8'd1, 0);
    wait_done("t7_done");
    seq_m++;
    end_checks("t7");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
